// File: rtl/n2t_serial_pkg.sv
// Shared definitions for the Hack serial link receive path.
//   rx_state_e           : receiver FSM states
//   DEFAULT_CLKS_PER_BIT : default oversampling ratio (clk cycles per bit)
//   DEFAULT_DATA_BITS    : default data bits per frame
//   EVEN / ODD           : parity-mode selectors
//   parity_mismatch()    : combines a data XOR-reduction with the received parity bit
package n2t_serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;
  localparam int unsigned DEFAULT_DATA_BITS    = 8;

  localparam bit EVEN = 1'b0;
  localparam bit ODD  = 1'b1;

  // 1 when the received parity bit disagrees with the data under the given mode.
  function automatic logic parity_mismatch(input logic data_xor,
                                           input logic par_bit,
                                           input logic odd);
    return data_xor ^ par_bit ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Mid-bit sample timer for the serial receiver.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear_i      : hold the counter at zero (used while idle)
//   half_i       : strobe after half a bit period instead of a full one
//   tick_o       : one-cycle sample strobe; the counter wraps to zero on it
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic half_i,
  output logic tick_o
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;

  always_comb begin
    tick = half_i ? (cnt_q == HALF_LAST) : (cnt_q == FULL_LAST);
    if (clear_i || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = tick;

endmodule

// File: rtl/uart_rx_parity.sv
// Asynchronous serial receiver (8N1/8E1/8O1) with parity check and a
// valid/ack holding register feeding the Hack character input path.
//   clk, reset_n : clock, asynchronous active-low reset
//   rx           : serial line, idles high, asynchronous to clk
//   rx_data      : last accepted byte
//   rx_valid     : rx_data holds an unconsumed byte
//   rx_ack       : consumer takes rx_data (only acts while rx_valid = 1)
//   parity_err   : parity of the held byte mismatched
//   frame_err    : stop bit of the held byte sampled low
//   overrun      : sticky, a byte was dropped while rx_valid was set
module uart_rx_parity
  import n2t_serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = DEFAULT_DATA_BITS,
  parameter bit          PARITY_EN    = 1'b1,
  parameter bit          PARITY_ODD   = EVEN
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned BCW = $clog2(DATA_BITS + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

  // Synchroniser, preset to the idle level so reset never looks like a start bit.
  logic rx_meta_q, rx_s_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  rx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                 par_err_q, par_err_d;
  logic                 timer_clear, timer_half, tick;
  logic                 load_req, stop_bad;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clear_i(timer_clear),
    .half_i (timer_half),
    .tick_o (tick)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    par_err_d   = par_err_q;
    timer_clear = 1'b0;
    timer_half  = 1'b0;
    load_req    = 1'b0;
    stop_bad    = 1'b0;

    case (state_q)
      IDLE: begin
        timer_clear = 1'b1;
        bit_cnt_d   = '0;
        par_err_d   = 1'b0;
        if (!rx_s_q) begin
          state_d = START;
        end
      end

      START: begin
        timer_half = 1'b1;
        if (tick) begin
          if (rx_s_q) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
      end

      DATA: begin
        if (tick) begin
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          // Counter holds at the last index; leaving DATA is what ends the byte.
          if (bit_cnt_q == LAST_BIT) begin
            state_d = PARITY_EN ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      PARITY: begin
        if (tick) begin
          par_err_d = parity_mismatch(^shift_q, rx_s_q, PARITY_ODD);
          state_d   = STOP;
        end
      end

      STOP: begin
        if (tick) begin
          load_req = 1'b1;
          stop_bad = ~rx_s_q;
          state_d  = rx_s_q ? IDLE : BREAK;
        end
      end

      BREAK: begin
        timer_clear = 1'b1;
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_err_q <= par_err_d;
    end
  end

  // Holding register.
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 accept;

  always_comb begin
    data_d = data_q;
    valid_d = valid_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    ovr_d = ovr_q;
    accept = rx_ack && valid_q;

    if (load_req) begin
      if (!valid_q || accept) begin
        data_d  = shift_q;
        valid_d = 1'b1;
        perr_d  = par_err_q;
        ferr_d  = stop_bad;
        // An ack coinciding with a load is a clean hand-over, so it still clears overrun.
        if (accept) begin
          ovr_d = 1'b0;
        end
      end else begin
        ovr_d = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule
